fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Single-outstanding instruction fetcher feeding a 2-entry decode FIFO.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam logic [31:0] c_reset_pc_aligned = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_fifo_pc    [0:1];
  logic [31:0] r_fifo_instr [0:1];
  logic [1:0]  r_count;

  logic        w_grant;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_redirect_pc;

  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req  = (r_state == S_IDLE) && (r_count < 2'd2) && !redirect;
  assign imem_addr = r_pc;
  assign w_grant   = imem_req && imem_gnt;
  // A redirect kills both the arriving response and any pop in the same cycle
  assign w_push    = (r_state == S_WAIT) && imem_rvalid && !redirect;
  assign w_pop     = (r_count != 2'd0) && id_ready && !redirect;

  assign id_valid = (r_count != 2'd0);
  assign id_instr = r_fifo_instr[0];
  assign id_pc    = r_fifo_pc[0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)   w_state_nxt = S_IDLE;
        else if (redirect) w_state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        if (imem_rvalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_pc            <= c_reset_pc_aligned;
      r_req_pc        <= 32'd0;
      r_count         <= 2'd0;
      r_fifo_pc[0]    <= 32'd0;
      r_fifo_pc[1]    <= 32'd0;
      r_fifo_instr[0] <= 32'd0;
      r_fifo_instr[1] <= 32'd0;
    end else begin
      r_state <= w_state_nxt;

      if (redirect)     r_pc <= w_redirect_pc;
      else if (w_grant) r_pc <= r_pc + 32'd4;

      if (w_grant) r_req_pc <= r_pc;

      if (redirect) r_count <= 2'd0;
      else          r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

      // Head stays at slot 0; a lone head is left in place on pop so outputs hold
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_fifo_pc[0]    <= r_req_pc;
            r_fifo_instr[0] <= imem_rdata;
          end else begin
            r_fifo_pc[1]    <= r_req_pc;
            r_fifo_instr[1] <= imem_rdata;
          end
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_fifo_pc[0]    <= r_fifo_pc[1];
            r_fifo_instr[0] <= r_fifo_instr[1];
          end
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_fifo_pc[0]    <= r_fifo_pc[1];
            r_fifo_instr[0] <= r_fifo_instr[1];
            r_fifo_pc[1]    <= r_req_pc;
            r_fifo_instr[1] <= imem_rdata;
          end else begin
            r_fifo_pc[0]    <= r_req_pc;
            r_fifo_instr[0] <= imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Randomized scoreboard bench for fetch_queue with an imem responder.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue;

  localparam logic [31:0] RST_PC     = 32'h0000_0002;
  localparam logic [31:0] RST_PC_EFF = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  always #5 clk = ~clk;

  fetch_queue #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory responder: one request at a time, data is a function of address
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_delay = 0;

  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_busy) begin
        if (mem_delay == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memfn(mem_addr);
        end else begin
          mem_delay--;
        end
      end
      imem_gnt = !mem_busy && (int'($urandom_range(0, 99)) < gnt_pct);
      @(negedge clk);
      if (imem_rvalid) mem_busy = 1'b0;
      if (imem_req && imem_gnt) begin
        mem_busy  = 1'b1;
        mem_addr  = imem_addr;
        mem_delay = int'($urandom_range(lat_min, lat_max));
      end
    end
  end

  // Reference model: program-order PC, the one in-flight fetch, and the decode-visible queue
  ent_t        expq[$];
  logic        model_ok = 1'b0;
  logic [31:0] mpc = 32'd0;
  logic        dut_out = 1'b0;
  logic        alive = 1'b0;
  logic [31:0] pend_pc = 32'd0;
  int          pops = 0;
  logic [31:0] last_pop_pc = 32'd0;
  logic        seen_wrap = 1'b0;

  initial begin
    logic exp_valid;
    logic exp_req;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        exp_valid = (expq.size() != 0);
        exp_req   = !dut_out && (expq.size() < 2) && !redirect;
        chk("id_valid", {31'd0, id_valid}, {31'd0, exp_valid});
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        chk("imem_addr", imem_addr, mpc);
        if (exp_valid) begin
          chk("id_pc", id_pc, expq[0].pc);
          chk("id_instr", id_instr, expq[0].instr);
        end
      end
      if (!rst_n) begin
        expq.delete();
        mpc      = RST_PC_EFF;
        dut_out  = 1'b0;
        alive    = 1'b0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        if (redirect) begin
          expq.delete();
          mpc   = redirect_pc & 32'hFFFF_FFFC;
          alive = 1'b0;
          if (imem_rvalid) dut_out = 1'b0;
        end else begin
          if (expq.size() != 0 && id_ready) begin
            if (last_pop_pc == 32'hFFFF_FFFC && expq[0].pc == 32'd0) seen_wrap = 1'b1;
            last_pop_pc = expq[0].pc;
            void'(expq.pop_front());
            pops++;
          end
          if (dut_out && imem_rvalid) begin
            if (alive) expq.push_back('{pc: pend_pc, instr: memfn(pend_pc)});
            dut_out = 1'b0;
            alive   = 1'b0;
          end
          if (imem_req && imem_gnt) begin
            dut_out = 1'b1;
            alive   = 1'b1;
            pend_pc = mpc;
            mpc     = mpc + 32'd4;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_outstanding(input string name);
    int i;
    i = 0;
    while (!dut_out && i < 50) begin cycles(1); i++; end
    chk(name, {31'd0, dut_out}, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    cycles(1);
    redirect = 1'b0; redirect_pc = $urandom;
  endtask

  initial begin
    int p0;
    int i;
    rst_n = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    @(posedge clk); #1;
    cycles(2);
    rst_n = 1'b1;

    // Post-reset outputs
    @(negedge clk);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_imem_addr", imem_addr, RST_PC_EFF);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back streaming: one instruction every two cycles
    id_ready = 1'b1;
    cycles(6);
    p0 = pops;
    cycles(20);
    chk("stream_rate", {31'd0, (pops - p0 >= 9) && (pops - p0 <= 10)}, 32'd1);

    // Saturation with decode stalled
    id_ready = 1'b0;
    do_redirect(32'd0);
    cycles(12);
    chk("sat_addr", imem_addr, 32'd8);
    chk("sat_req", {31'd0, imem_req}, 32'd0);
    chk("sat_head", id_pc, 32'd0);
    id_ready = 1'b1;
    cycles(10);

    // Redirect while a fetch is outstanding, response still pending
    lat_min = 2; lat_max = 2;
    wait_outstanding("wait_req_034");
    do_redirect(32'h0000_0103);
    chk("redir_flush", {31'd0, id_valid}, 32'd0);
    i = 0;
    while (!id_valid && i < 30) begin cycles(1); i++; end
    @(negedge clk);
    chk("redir_first_pc", id_pc, 32'h0000_0100);
    @(posedge clk); #1;

    // Redirect coincident with the response and a pop
    lat_min = 0; lat_max = 0;
    cycles(4);
    wait_outstanding("wait_req_035");
    do_redirect(32'h0000_2000);
    @(negedge clk);
    chk("redir_rv_addr", imem_addr, 32'h0000_2000);
    @(posedge clk); #1;

    // Address wrap at the top of memory
    do_redirect(32'hFFFF_FFF8);
    cycles(12);
    chk("wrap_seen", {31'd0, seen_wrap}, 32'd1);

    // Reset abandons an outstanding fetch; the late response must be ignored
    lat_min = 3; lat_max = 3;
    wait_outstanding("wait_req_037");
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_addr", imem_addr, RST_PC_EFF);
    @(posedge clk); #1;
    cycles(15);

    // Randomized traffic
    gnt_pct = 60; lat_min = 0; lat_max = 3;
    for (int k = 0; k < 4000; k++) begin
      id_ready    = ($urandom_range(0, 99) < 70);
      redirect    = ($urandom_range(0, 99) < 4);
      redirect_pc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      rst_n       = !($urandom_range(0, 999) < 3);
      cycles(1);
    end
    redirect = 1'b0; rst_n = 1'b1;
    cycles(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
